// File: rtl/sipo_capture.sv
// Serial-in/parallel-out capture stage: assembles WIDTH strobed bits from the latch into a
// word and offers it on a valid/ready handshake, flagging words lost to back-pressure.
module sipo_capture #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sin,
   input  logic                       sin_en,
   input  logic                       start,
   input  logic                       out_ready,
   input  logic                       clr_ovr,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       overrun
);

   localparam int CW = $clog2(WIDTH+1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic             last_bit;
   logic             transfer;

   always_comb begin
      sr_next = {sin, sr[WIDTH-1:1]};
      if (MSB_FIRST != 0) begin
         sr_next = {sr[WIDTH-2:0], sin};
      end
   end

   assign last_bit = (bit_cnt == CW'(WIDTH-1));
   assign transfer = out_valid & out_ready;

   // Later non-blocking assignments override earlier defaults, so a load beats the
   // transfer-clear of out_valid and a drop beats clr_ovr.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         bit_cnt   <= '0;
         sr        <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (transfer) begin
            out_valid <= 1'b0;
         end
         if (clr_ovr) begin
            overrun <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SHIFT;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  sr      <= '0;
               end
            end
            SHIFT: begin
               if (start) begin
                  bit_cnt <= '0;
                  sr      <= '0;
               end else if (sin_en) begin
                  sr <= sr_next;
                  if (last_bit) begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     bit_cnt <= '0;
                     if (!out_valid || transfer) begin
                        out_valid <= 1'b1;
                        out_data  <= sr_next;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_capture.sv
// Self-checking bench for sipo_capture: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a frame-level model built from a queue of received bits.
module tb_sipo_capture;

   localparam int W  = 8;
   localparam int CW = $clog2(W+1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, sin, sin_en, start, out_ready, clr_ovr;
   logic [W-1:0]  data_m, data_l;
   logic          valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
   logic [CW-1:0] cnt_m, cnt_l;

   sipo_capture #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start),
      .out_ready(out_ready), .clr_ovr(clr_ovr), .out_data(data_m),
      .out_valid(valid_m), .busy(busy_m), .bit_cnt(cnt_m), .overrun(ovr_m)
   );

   sipo_capture #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start),
      .out_ready(out_ready), .clr_ovr(clr_ovr), .out_data(data_l),
      .out_valid(valid_l), .busy(busy_l), .bit_cnt(cnt_l), .overrun(ovr_l)
   );

   // Reference model: frame in progress plus the list of bits received so far.
   bit         m_busy  = 1'b0;
   int         bits[$];
   bit         m_valid = 1'b0;
   bit         m_ovr   = 1'b0;
   logic [W-1:0] m_dm  = '0;
   logic [W-1:0] m_dl  = '0;

   int asserts = 0;
   int fails   = 0;

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
      asserts++;
      assert (got === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic checkOutput();
      cmp("msb_data",  data_m,  m_dm);
      cmp("lsb_data",  data_l,  m_dl);
      cmp("msb_valid", valid_m, m_valid);
      cmp("lsb_valid", valid_l, m_valid);
      cmp("msb_busy",  busy_m,  m_busy);
      cmp("lsb_busy",  busy_l,  m_busy);
      cmp("msb_cnt",   cnt_m,   bits.size());
      cmp("lsb_cnt",   cnt_l,   bits.size());
      cmp("msb_ovr",   ovr_m,   m_ovr);
      cmp("lsb_ovr",   ovr_l,   m_ovr);
   endtask

   task automatic modelStep();
      bit done = 1'b0;
      bit xfer;
      logic [W-1:0] wm = '0;
      logic [W-1:0] wl = '0;
      if (rst) begin
         m_busy = 0; bits.delete(); m_valid = 0; m_ovr = 0; m_dm = '0; m_dl = '0;
         return;
      end
      if (start) begin
         m_busy = 1; bits.delete();
      end else if (m_busy && sin_en) begin
         bits.push_back(int'(sin));
         if (bits.size() == W) begin
            done = 1;
            for (int i = 0; i < W; i++) begin
               wm = wm + ((bits[i] != 0) ? (W'(1) << (W-1-i)) : '0);
               wl = wl + ((bits[i] != 0) ? (W'(1) << i) : '0);
            end
            m_busy = 0;
            bits.delete();
         end
      end
      xfer = m_valid && out_ready;
      if (clr_ovr) m_ovr = 0;
      if (xfer) m_valid = 0;
      if (done) begin
         if (!m_valid) begin
            m_valid = 1; m_dm = wm; m_dl = wl;
         end else begin
            m_ovr = 1;
         end
      end
   endtask

   // One clock: drive on the falling edge, check 1 ns after the rising edge.
   task automatic applyStimulus(input logic r, input logic s, input logic e, input logic d,
                                input logic rdy, input logic c);
      @(negedge clk);
      rst = r; start = s; sin_en = e; sin = d; out_ready = rdy; clr_ovr = c;
      modelStep();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic sendBits(input logic [W-1:0] pat, input int n, input bit gaps, input logic rdy);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 1, pat[W-1-i], rdy, 0);
         if (gaps) applyStimulus(0, 0, 0, 1'($urandom), rdy, 0);
      end
   endtask

   initial begin
      $display("[TB] sipo_capture test start");
      // Reset with random other inputs
      for (int i = 0; i < 2; i++)
         applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);
      cmp("reset_valid", valid_m, 0);

      // MSB-first word with ready high; lsb instance sees the same bits
      applyStimulus(0, 1, 1, 1, 1, 0);
      cmp("busy_after_start", busy_m, 1);
      sendBits(8'hB2, 8, 0, 1);
      cmp("word_b2", data_m, 8'hB2);
      cmp("word_4d", data_l, 8'h4D);
      cmp("valid_one", valid_m, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      cmp("valid_one_cycle", valid_m, 0);

      // LSB-first with strobe gaps
      applyStimulus(0, 1, 0, 0, 1, 0);
      sendBits(8'hB2, 8, 1, 1);
      cmp("gap_word_4d", data_l, 8'h4D);

      // Back-pressure and overrun
      applyStimulus(0, 1, 0, 0, 0, 0);
      sendBits(8'hB2, 8, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      sendBits(8'hFF, 8, 0, 0);
      cmp("ovr_hold_data", data_m, 8'hB2);
      cmp("ovr_set", ovr_m, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      cmp("ovr_drain", valid_m, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      cmp("ovr_clear", ovr_m, 0);

      // Simultaneous transfer and load
      applyStimulus(0, 1, 0, 0, 0, 0);
      sendBits(8'hB2, 8, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0);
      sendBits(8'h3C, 7, 0, 0);
      applyStimulus(0, 0, 1, 1'b0, 1, 0);
      cmp("swap_valid", valid_m, 1);
      cmp("swap_data", data_m, 8'h3C);
      cmp("swap_ovr", ovr_m, 0);
      applyStimulus(0, 0, 0, 0, 1, 0);

      // Restart mid-frame, then reset mid-frame
      applyStimulus(0, 1, 0, 0, 1, 0);
      sendBits(8'hE0, 3, 0, 1);
      applyStimulus(0, 1, 1, 1, 1, 0);
      sendBits(8'hA5, 8, 0, 1);
      cmp("restart_a5", data_m, 8'hA5);
      applyStimulus(0, 1, 0, 0, 1, 0);
      sendBits(8'hF8, 5, 0, 1);
      applyStimulus(1, 0, 1, 1, 1, 0);
      cmp("midreset_cnt", cnt_m, 0);
      cmp("midreset_valid", valid_m, 0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0),
                       ($urandom_range(0, 3) != 0), 1'($urandom),
                       1'($urandom), ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/sipo_capture.md
# sipo_capture

Serial-in/parallel-out capture stage placed directly downstream of the gated D latch. It samples the latch's `q` output one bit per strobe and assembles `WIDTH` bits into a word. The completed word goes out on a valid/ready handshake, and a sticky flag reports any word lost to back-pressure. A start pulse frames each word.

## Interface
Parameters:
- `WIDTH`, default 8: word length in bits; legal range 2–32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in `out_data[WIDTH-1]`; 0 means it lands in `out_data[0]`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `sin`, input, 1: serial data bit, driven from the latch's `q`.
- `sin_en`, input, 1: bit strobe; `sin` is sampled on cycles where this is 1.
- `start`, input, 1: begins a new frame (one-cycle pulse).
- `out_ready`, input, 1: consumer can accept `out_data`.
- `clr_ovr`, input, 1: clears `overrun`.
- `out_data`, output, `WIDTH`: assembled word.
- `out_valid`, output, 1: `out_data` holds an unconsumed word.
- `busy`, output, 1: a frame is in progress (state SHIFT).
- `bit_cnt`, output, `$clog2(WIDTH+1)`: bits received in the current frame.
- `overrun`, output, 1: sticky; a completed word was dropped.

## Operation
- States:
  - IDLE: waits for a frame.
  - SHIFT: collects bits.
- Reset (`rst`=1 at a clock edge) puts every output to 0:
  - state = IDLE, `busy` = 0, `bit_cnt` = 0, shift register = 0.
  - `out_data` = 0, `out_valid` = 0, `overrun` = 0.
  - Reset has priority over every other input, including in the middle of a frame; a partial word is discarded.
- IDLE → SHIFT on `start`=1. On entry, `bit_cnt` = 0 and the shift register is cleared. `sin_en` in the same cycle as `start` is ignored.
- In SHIFT, each cycle with `sin_en`=1:
  - MSB_FIRST=1: shift register becomes `{sr[WIDTH-2:0], sin}`.
  - MSB_FIRST=0: shift register becomes `{sin, sr[WIDTH-1:1]}`.
  - `bit_cnt` increments.
- Cycles with `sin_en`=0 hold all state.
- Completion is the strobe that brings `bit_cnt` to `WIDTH`. On completion:
  - The assembled word (including that bit) is offered to the output register.
  - State returns to IDLE.
  - `bit_cnt` returns to 0.
- `start`=1 while in SHIFT restarts the frame: `bit_cnt` = 0, shift register cleared, state stays SHIFT, and `sin_en` in that cycle is ignored. `start` has priority over completion in the same cycle.
- Output register rules:
  - A transfer occurs when `out_valid` & `out_ready`. It clears `out_valid` unless a new word loads in the same cycle.
  - A new word loads only if `out_valid`=0, or a transfer happens in the same cycle. Otherwise the new word is dropped, `out_data` is unchanged, and `overrun` is set to 1.
  - While `out_valid`=1 and no transfer occurs, `out_data` is stable.
  - `out_valid` never drops without a transfer.
- `overrun` clears on `clr_ovr`=1. If a set event and `clr_ovr` occur in the same cycle, the set wins.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `busy` rises the cycle after `start` is sampled.
- `out_valid` and `out_data` update in the cycle after the completing strobe.
- `busy` falls in that same cycle.
- Minimum frame: `start` + `WIDTH` strobe cycles. `out_valid` rises `WIDTH`+1 cycles after `start` when `sin_en` is held at 1.
- Back-to-back frames are allowed. A `start` in the cycle right after completion is accepted.
- `sin` must be stable around the rising edge when `sin_en`=1. Because the latch's output settles within 2 ns of its last input change (two 1 ns gate delays), `sin` and `sin_en` must be driven from the opposite clock phase, or be at least 2 ns after the latch's last input change.

## Test plan
1. Reset: `rst`=1 for 2 cycles with random inputs → all outputs 0. Release, then 5 idle cycles → outputs still 0, `busy`=0.
2. MSB-first word: `WIDTH`=8, `MSB_FIRST`=1, `out_ready`=1, `start`, then bits 1,0,1,1,0,0,1,0 on consecutive strobes → `out_data`=0xB2 and `out_valid`=1 for exactly one cycle, `busy`=0 afterwards.
3. LSB-first with gaps: same bits, `MSB_FIRST`=0, `sin_en` toggled 1/0 → `out_data`=0x4D; `bit_cnt` steps 1..7 and holds during gaps.
4. Back-pressure and overrun: `out_ready`=0, two full frames (0xB2, then 0xFF) → `out_data` stays 0xB2, `out_valid`=1, `overrun`=1. Raise `out_ready` → one transfer of 0xB2. Pulse `clr_ovr` → `overrun`=0.
5. Simultaneous transfer and load: `out_valid`=1 with 0xB2, `out_ready`=1 in the completion-load cycle of 0x3C → `out_valid` stays 1, `out_data`=0x3C, `overrun`=0.
6. Restart and mid-frame reset:
   - 3 bits, then `start`, then 8 bits of 0xA5 → `out_data`=0xA5.
   - 5 bits, then `rst` → `bit_cnt`=0, no `out_valid`.
